// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA timing constants (640x480@60) and the sync decoder state
// encoding. The same constants drive the hsync/vsync generators.
package vga_timing_pkg;

  localparam int VGA_CW          = 12;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BACK      = 48;
  localparam int VGA_H_START     = VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_H_ACTIVE    = 640;

  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BACK      = 33;
  localparam int VGA_V_START     = VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_V_ACTIVE    = 480;

  localparam logic VGA_H_POL     = 1'b0;
  localparam logic VGA_V_POL     = 1'b0;

  localparam int VGA_LOCK_FRAMES = 2;

  // Decoder lock state encoding.
  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // True when lo <= val < lo + len.
  function automatic logic in_window(input int val, input int lo, input int len);
    return (val >= lo) && (val < (lo + len));
  endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser for an asynchronous sync input,
// a history flop, and a registered one-cycle strobe on the
// inactive-to-active transition. Input edge to strobe is 3 clocks.
module sync_edge_detect #(
  parameter logic POL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_lead
);

  localparam logic IDLE = ~POL;

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;
  logic lead_q, lead_d;

  // Next-state for the synchroniser chain and the leading-edge strobe.
  always_comb begin
    meta_d = i_sync;
    sync_d = meta_q;
    hist_d = sync_q;
    lead_d = (sync_q == POL) && (hist_q != POL);
  end

  // Chain registers; reset holds the inactive sync level so no false edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= IDLE;
      sync_q <= IDLE;
      hist_q <= IDLE;
      lead_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
      lead_q <= lead_d;
    end
  end

  assign o_lead = lead_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, an active-video strobe and
// lock status from an incoming hsync/vsync pair, measuring line period and
// frame height against the expected mode.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int   CW          = VGA_CW,
  parameter int   H_TOTAL     = VGA_H_TOTAL,
  parameter int   V_TOTAL     = VGA_V_TOTAL,
  parameter int   H_START     = VGA_H_START,
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   V_START     = VGA_V_START,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter logic H_POL       = VGA_H_POL,
  parameter logic V_POL       = VGA_V_POL,
  parameter int   LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_hsync,
  input  logic          i_vsync,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_active,
  output logic          o_locked,
  output logic          o_mode_err,
  output logic [CW-1:0] o_line_len,
  output logic [CW-1:0] o_frame_lines
);

  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAXV = {CW{1'b1}};
  localparam logic [CW-1:0] HT   = CW'(H_TOTAL);
  localparam logic [CW-1:0] VT   = CW'(V_TOTAL);
  localparam logic [CW-1:0] HS   = CW'(H_START);
  localparam logic [CW-1:0] VS   = CW'(V_START);
  localparam logic [CW-1:0] WD   = CW'(2 * H_TOTAL);
  localparam logic [3:0]    LF   = 4'(LOCK_FRAMES);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAXV) ? v : v + ONE;
  endfunction

  logic          h_lead;
  logic          v_lead;

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [CW-1:0] line_len_q, line_len_d;
  logic [CW-1:0] frame_lines_q, frame_lines_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    match_q, match_d;
  logic          line_bad_q, line_bad_d;
  logic          skip_q, skip_d;
  logic          mode_err_q, mode_err_d;
  logic          locked_q, locked_d;
  logic          active_q, active_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;

  logic [CW-1:0] cur_len;
  logic [CW-1:0] cur_lines;
  logic          line_err;
  logic          wd_err;
  logic          frame_ok;

  sync_edge_detect #(
    .POL (H_POL)
  ) u_hsync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sync  (i_hsync),
    .o_lead  (h_lead)
  );

  sync_edge_detect #(
    .POL (V_POL)
  ) u_vsync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sync  (i_vsync),
    .o_lead  (v_lead)
  );

  // Measurements of the line / frame ending in this cycle. Line checks are
  // suppressed in SEARCH and for the first (possibly partial) line after it.
  assign cur_len   = sat_inc(hcnt_q);
  assign cur_lines = sat_inc(vcnt_q);
  assign line_err  = h_lead && (state_q != ST_SEARCH) && !skip_q && (cur_len != HT);
  assign wd_err    = !h_lead && (state_q != ST_SEARCH) && (hcnt_q == WD);
  assign frame_ok  = (cur_lines == VT);

  // Pixel/line counters and the last measured line period / frame height.
  always_comb begin
    hcnt_d = h_lead ? ZERO : sat_inc(hcnt_q);
    if (v_lead) begin
      vcnt_d = ZERO;
    end else if (h_lead) begin
      vcnt_d = sat_inc(vcnt_q);
    end else begin
      vcnt_d = vcnt_q;
    end
    line_len_d    = h_lead ? cur_len : line_len_q;
    frame_lines_d = v_lead ? cur_lines : frame_lines_q;
  end

  // Partial-line mask: armed when measurement starts, cleared by the next h_lead.
  always_comb begin
    if ((state_q == ST_SEARCH) && v_lead) begin
      skip_d = 1'b1;
    end else if (h_lead) begin
      skip_d = 1'b0;
    end else begin
      skip_d = skip_q;
    end
  end

  // Lock state machine: count consecutive good frames, drop lock on any error.
  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    line_bad_d = line_bad_q;
    mode_err_d = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (v_lead) begin
          state_d    = ST_MEASURE;
          match_d    = 4'd0;
          line_bad_d = 1'b0;
        end else begin
          state_d    = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (v_lead) begin
          line_bad_d = 1'b0;
          if (!line_bad_q && !line_err && !wd_err && frame_ok) begin
            if ((match_q + 4'd1) == LF) begin
              state_d = ST_LOCKED;
              match_d = LF;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            match_d = 4'd0;
          end
        end else if (line_err || wd_err) begin
          line_bad_d = 1'b1;
        end else begin
          line_bad_d = line_bad_q;
        end
      end
      ST_LOCKED: begin
        if (line_err || wd_err || (v_lead && !frame_ok)) begin
          state_d    = ST_SEARCH;
          match_d    = 4'd0;
          line_bad_d = 1'b0;
          mode_err_d = 1'b1;
        end else if (v_lead) begin
          line_bad_d = 1'b0;
        end else begin
          line_bad_d = line_bad_q;
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        match_d    = 4'd0;
        line_bad_d = 1'b0;
      end
    endcase
  end

  // Output decode from the current counters; lock and active share state_d
  // so o_active drops in the same cycle as o_locked.
  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    active_d = locked_d
               && in_window(int'(hcnt_q), H_START, H_ACTIVE)
               && in_window(int'(vcnt_q), V_START, V_ACTIVE);
    if (active_d) begin
      x_d = hcnt_q - HS;
      y_d = vcnt_q - VS;
    end else begin
      x_d = ZERO;
      y_d = ZERO;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt_q        <= ZERO;
      vcnt_q        <= ZERO;
      line_len_q    <= ZERO;
      frame_lines_q <= ZERO;
      state_q       <= ST_SEARCH;
      match_q       <= 4'd0;
      line_bad_q    <= 1'b0;
      skip_q        <= 1'b0;
      mode_err_q    <= 1'b0;
      locked_q      <= 1'b0;
      active_q      <= 1'b0;
      x_q           <= ZERO;
      y_q           <= ZERO;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      state_q       <= state_d;
      match_q       <= match_d;
      line_bad_q    <= line_bad_d;
      skip_q        <= skip_d;
      mode_err_q    <= mode_err_d;
      locked_q      <= locked_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_active      = active_q;
  assign o_locked      = locked_q;
  assign o_mode_err    = mode_err_q;
  assign o_line_len    = line_len_q;
  assign o_frame_lines = frame_lines_q;

endmodule
